fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 52 +++++
 rtl/fetch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if -- PC-control bundle between the fetch controller and the
// pipeline front end.
//
// Signals
//   pc_i             current PC from the program counter
//   imem_ready_i     instruction memory has valid data for pc_i
//   hazard_stall_i   pipeline hazard, hold fetch
//   branch_taken_i   resolved taken branch/jump (single-cycle pulse)
//   branch_target_i  branch destination, valid with branch_taken_i
//   irq_i            level-sensitive interrupt request
//   reti_i           return-from-interrupt (single-cycle pulse)
//   pc_load_o        PC load enable
//   pc_target_o      PC load value (8'h00 when not loading)
//   pc_stall_o       PC hold
//   flush_o          discard fetched/decoded instruction
//   irq_ack_o        one-cycle interrupt acceptance pulse
//   epc_o            saved return address
//   ie_o             interrupt enable flag
//
// Modports
//   master  fetch controller side (drives the PC control outputs)
//   slave   pipeline / PC side
interface fetch_ctrl_if;
   logic [7:0] pc_i;
   logic       imem_ready_i;
   logic       hazard_stall_i;
   logic       branch_taken_i;
   logic [7:0] branch_target_i;
   logic       irq_i;
   logic       reti_i;
   logic       pc_load_o;
   logic [7:0] pc_target_o;
   logic       pc_stall_o;
   logic       flush_o;
   logic       irq_ack_o;
   logic [7:0] epc_o;
   logic       ie_o;

   modport master (
      input  pc_i, imem_ready_i, hazard_stall_i, branch_taken_i,
             branch_target_i, irq_i, reti_i,
      output pc_load_o, pc_target_o, pc_stall_o, flush_o, irq_ack_o,
             epc_o, ie_o
   );

   modport slave (
      output pc_i, imem_ready_i, hazard_stall_i, branch_taken_i,
             branch_target_i, irq_i, reti_i,
      input  pc_load_o, pc_target_o, pc_stall_o, flush_o, irq_ack_o,
             epc_o, ie_o
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller. Decides each cycle whether the
// PC increments, holds, or is redirected (branch, interrupt entry, return
// from interrupt), and drives the flush that follows every redirect.
//
// Parameters
//   IRQ_VECTOR    PC target on interrupt entry
//   FLUSH_CYCLES  cycles flush_o stays high after the redirect cycle (1..7)
//
// Ports
//   clk_i    single clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      fetch_ctrl_if.master, see the interface for signal list
//
// State | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal fetch; redirects, irq accept, stalls evaluated by priority
// WAIT_MEM | memory not ready; PC held, arriving branch latched as pending
// FLUSH | post-redirect drain; counts down FLUSH_CYCLES, events ignored
module fetch_ctrl #(
   parameter logic [7:0]  IRQ_VECTOR   = 8'hF0,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_MEM = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   state_t     state_q, state_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
   logic       pend_q, pend_d;
   logic [7:0] pend_tgt_q, pend_tgt_d;
   logic [7:0] epc_q, epc_d;
   logic       ie_q, ie_d;

   logic       load;
   logic [7:0] target;
   logic       stall;
   logic       flush;
   logic       ack;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= RUN;
         flush_cnt_q <= 3'd0;
         pend_q      <= 1'b0;
         pend_tgt_q  <= 8'h00;
         epc_q       <= 8'h00;
         ie_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         pend_q      <= pend_d;
         pend_tgt_q  <= pend_tgt_d;
         epc_q       <= epc_d;
         ie_q        <= ie_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pend_d      = pend_q;
      pend_tgt_d  = pend_tgt_q;
      epc_d       = epc_q;
      ie_d        = ie_q;
      load        = 1'b0;
      target      = 8'h00;
      stall       = 1'b0;
      flush       = 1'b0;
      ack         = 1'b0;

      case (state_q)
         RUN: begin
            if (bus.branch_taken_i) begin
               load        = 1'b1;
               target      = bus.branch_target_i;
               flush       = 1'b1;
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_INIT;
            end else if (bus.reti_i) begin
               load        = 1'b1;
               target      = epc_q;
               flush       = 1'b1;
               ie_d        = 1'b1;
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_INIT;
            end else if (bus.irq_i && ie_q) begin
               load        = 1'b1;
               target      = IRQ_VECTOR;
               flush       = 1'b1;
               ack         = 1'b1;
               epc_d       = bus.pc_i;
               ie_d        = 1'b0;
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_INIT;
            end else if (!bus.imem_ready_i) begin
               stall   = 1'b1;
               state_d = WAIT_MEM;
            end else if (bus.hazard_stall_i) begin
               stall = 1'b1;
            end
         end

         WAIT_MEM: begin
            if (!bus.imem_ready_i) begin
               stall = 1'b1;
               // Latest branch wins; irq and reti are deliberately not seen here.
               if (bus.branch_taken_i) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = bus.branch_target_i;
               end
            end else if (bus.branch_taken_i || pend_q) begin
               // A branch landing on the ready cycle is newer than the pending one.
               load        = 1'b1;
               target      = bus.branch_taken_i ? bus.branch_target_i : pend_tgt_q;
               flush       = 1'b1;
               pend_d      = 1'b0;
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_INIT;
            end else begin
               stall   = bus.hazard_stall_i;
               state_d = RUN;
            end
         end

         FLUSH: begin
            flush       = 1'b1;
            stall       = !bus.imem_ready_i;
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) begin
               state_d     = RUN;
               flush_cnt_d = 3'd0;
            end
         end

         default: begin
            state_d     = RUN;
            flush_cnt_d = 3'd0;
            pend_d      = 1'b0;
         end
      endcase
   end

   // Combinational outputs are forced low while reset is held.
   assign bus.pc_load_o   = rst_n_i & load;
   assign bus.pc_target_o = rst_n_i ? target : 8'h00;
   assign bus.pc_stall_o  = rst_n_i & stall;
   assign bus.flush_o     = rst_n_i & flush;
   assign bus.irq_ack_o   = rst_n_i & ack;
   assign bus.epc_o       = epc_q;
   assign bus.ie_o        = ie_q;

   a_load_stall_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(bus.pc_load_o && bus.pc_stall_o));

   a_target_zero: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !bus.pc_load_o |-> bus.pc_target_o == 8'h00);

   a_ack_implies_load: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      bus.irq_ack_o |-> (bus.pc_load_o && bus.pc_target_o == IRQ_VECTOR));

endmodule
